// File: rtl/permute_pkg.sv
// Shared types and encodings for the odd-pipe permute issue path.
package permute_pkg;

  localparam int OP_W  = 11;
  localparam int FMT_W = 3;
  localparam int REG_W = 7;
  localparam int IMM_W = 18;

  localparam logic [0:OP_W-1]  NOP_OP  = '0;
  localparam logic [FMT_W-1:0] NOP_FMT = '0;

  // One in-flight destination tracked by the issue scoreboard.
  typedef struct packed {
    logic            valid;
    logic [0:REG_W-1] rt;
  } sb_entry_t;

  // A NOP never occupies a scoreboard entry, whatever its reg_write bit says.
  function automatic logic is_nop(input logic [0:OP_W-1] op, input logic [FMT_W-1:0] fmt);
    return (op == NOP_OP) && (fmt == NOP_FMT);
  endfunction

endpackage

// File: rtl/permute_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last granted slot.
module permute_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] elig,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  // Grant: a lone eligible slot wins, a tie goes to the slot not granted last.
  always_comb begin
    grant = elig;
    if (elig == 2'b11) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
  end

  // Pointer only moves when a grant is actually issued.
  always_comb begin
    last_d = last_q;
    if (grant[1]) begin
      last_d = 1'b1;
    end else if (grant[0]) begin
      last_d = 1'b0;
    end
  end

  // Pointer register; reset to 1 so slot 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/permute_issue_ctrl.sv
// Issue controller for the permute unit: RAW scoreboard, dual-slot arbitration,
// registered drive of the unit's control inputs, branch squash and stall counting.
module permute_issue_ctrl
  import permute_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][0:OP_W-1]   req_op,
  input  logic [1:0][FMT_W-1:0]  req_format,
  input  logic [1:0][0:REG_W-1]  req_rt_addr,
  input  logic [1:0][0:REG_W-1]  req_ra_addr,
  input  logic [1:0][0:REG_W-1]  req_rb_addr,
  input  logic [1:0]             req_uses_rb,
  input  logic [1:0][0:IMM_W-1]  req_imm,
  input  logic [1:0]             req_reg_write,
  input  logic                   flush,
  output logic [0:OP_W-1]        pu_op,
  output logic [FMT_W-1:0]       pu_format,
  output logic [0:REG_W-1]       pu_rt_addr,
  output logic [0:IMM_W-1]       pu_imm,
  output logic                   pu_reg_write,
  output logic                   pu_sel,
  output logic [CNT_W-1:0]       stall_cnt
);

  // Entry 0 is the instruction being granted this cycle and is produced
  // combinationally from the grant; entries 1..DEPTH-1 are registered. Entry 1
  // is what the unit sees this cycle, entries 2.. are inside the permute stages.
  sb_entry_t sb_q [1:DEPTH-1];
  sb_entry_t sb_d [1:DEPTH-1];

  logic [1:0]         hazard;
  logic [1:0]         elig;
  logic [1:0]         grant;
  logic               gnt_any;
  logic               gnt_slot;

  logic [0:OP_W-1]    pu_op_q,  pu_op_d;
  logic [FMT_W-1:0]   pu_fmt_q, pu_fmt_d;
  logic [0:REG_W-1]   pu_rt_q,  pu_rt_d;
  logic [0:IMM_W-1]   pu_imm_q, pu_imm_d;
  logic               pu_rw_q,  pu_rw_d;
  logic               pu_sel_q, pu_sel_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Hazard: any live source matches any in-flight destination (no forwarding).
  always_comb begin
    hazard = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = 1; i < DEPTH; i++) begin
        if (sb_q[i].valid) begin
          if (req_ra_addr[s] == sb_q[i].rt) begin
            hazard[s] = 1'b1;
          end
          if (req_uses_rb[s] && (req_rb_addr[s] == sb_q[i].rt)) begin
            hazard[s] = 1'b1;
          end
        end
      end
    end
  end

  assign elig = req_valid & ~hazard & {2{~flush}};

  permute_rr_arb u_arb (
    .clk   (clk),
    .reset (reset),
    .elig  (elig),
    .grant (grant)
  );

  assign gnt_any   = |grant;
  assign gnt_slot  = grant[1];
  assign req_ready = reset ? 2'b00 : grant;

  // Unit drive: granted slot's fields, otherwise an all-zero NOP; operand mux
  // select only moves on a grant.
  always_comb begin
    pu_op_d  = '0;
    pu_fmt_d = '0;
    pu_rt_d  = '0;
    pu_imm_d = '0;
    pu_rw_d  = 1'b0;
    pu_sel_d = pu_sel_q;
    if (gnt_any) begin
      pu_op_d  = req_op[gnt_slot];
      pu_fmt_d = req_format[gnt_slot];
      pu_rt_d  = req_rt_addr[gnt_slot];
      pu_imm_d = req_imm[gnt_slot];
      pu_rw_d  = req_reg_write[gnt_slot];
      pu_sel_d = gnt_slot;
    end
  end

  // Scoreboard shift; flush kills the unit's current instruction (entry 1),
  // and the grant is already blocked so entry 0 loads empty.
  always_comb begin
    sb_d[1] = '0;
    if (gnt_any && req_reg_write[gnt_slot] &&
        !is_nop(req_op[gnt_slot], req_format[gnt_slot])) begin
      sb_d[1].valid = 1'b1;
      sb_d[1].rt    = req_rt_addr[gnt_slot];
    end
    for (int i = 2; i < DEPTH; i++) begin
      sb_d[i] = sb_q[i-1];
    end
    if (flush) begin
      sb_d[2] = '0;
    end
  end

  // Stall counter: requests waiting with no grant, ignoring squash cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((|req_valid) && !gnt_any && !flush) begin
      stall_cnt_d = sat_inc(stall_cnt_q);
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 1; i < DEPTH; i++) begin
        sb_q[i] <= '0;
      end
      pu_op_q     <= '0;
      pu_fmt_q    <= '0;
      pu_rt_q     <= '0;
      pu_imm_q    <= '0;
      pu_rw_q     <= 1'b0;
      pu_sel_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        sb_q[i] <= sb_d[i];
      end
      pu_op_q     <= pu_op_d;
      pu_fmt_q    <= pu_fmt_d;
      pu_rt_q     <= pu_rt_d;
      pu_imm_q    <= pu_imm_d;
      pu_rw_q     <= pu_rw_d;
      pu_sel_q    <= pu_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pu_op        = pu_op_q;
  assign pu_format    = pu_fmt_q;
  assign pu_rt_addr   = pu_rt_q;
  assign pu_imm       = pu_imm_q;
  assign pu_reg_write = pu_rw_q;
  assign pu_sel       = pu_sel_q;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: doc/permute_issue_ctrl.md
# permute_issue_ctrl

Issue controller and scoreboard for the odd-pipe permute unit. Two requesters (dual-issue slots 0 and 1) share the single permute datapath. The block arbitrates round-robin and holds any request whose source registers are still in flight in the permute pipeline. It drives the unit's op/format/rt_addr/imm/reg_write inputs from registers and squashes in-flight state on a taken branch.

## Interface
- DEPTH, 4: scoreboard entries; cycles from acceptance to register-file write (1 issue register + 3 permute stages).
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  [1:0]  request present per slot
- req_ready  out  [1:0]  request accepted this edge when valid&ready
- req_op  in  [1:0][0:10]  decoded opcode
- req_format  in  [1:0][2:0]  instruction format
- req_rt_addr  in  [1:0][0:6]  destination register
- req_ra_addr, req_rb_addr  in  [1:0][0:6]  source registers
- req_uses_rb  in  [1:0]  rb is a real source (0 for immediate forms)
- req_imm  in  [1:0][0:17]  immediate
- req_reg_write  in  [1:0]  instruction writes rt
- flush  in  1  branch taken; tied with the permute unit's branch_taken
- pu_op  out  [0:10]  to permute unit
- pu_format  out  [2:0]  to permute unit
- pu_rt_addr  out  [0:6]  to permute unit
- pu_imm  out  [0:17]  to permute unit
- pu_reg_write  out  1  to permute unit
- pu_sel  out  1  slot whose ra/rb the operand mux routes to the unit
- stall_cnt  out  [CNT_W-1:0]  saturating count of hazard-stall cycles

## Operation
- Scoreboard: a DEPTH-entry shift register of {valid, rt_addr}. Every edge it shifts one place. The entry at index DEPTH-1 is dropped, which means its result is now in the register file.
- On acceptance of an instruction with reg_write=1, entry 0 loads {1, rt}. Otherwise entry 0 loads {0, 0}.
- A NOP (format==0 && op==0) never sets a scoreboard entry, whatever reg_write says.
- Hazard for slot s:
  - req_ra_addr[s] matches any valid entry's rt_addr, or
  - req_uses_rb[s] && req_rb_addr[s] matches any valid entry.
  - Comparison covers all DEPTH entries, including the one loaded this cycle; there is no forwarding.
- Eligible[s] = req_valid[s] && !hazard[s] && !flush.
- Arbitration: round-robin with a 1-bit last-grant pointer, reset 1 so slot 0 wins first.
  - If both slots are eligible, grant goes to the slot that was not last granted.
  - At most one grant per cycle.
  - The pointer updates only on a grant.
- req_ready[s] = grant[s]; it is combinational from the current state and inputs.
- On a grant, pu_* and pu_sel are loaded from the granted slot at the edge. With no grant, pu_* load all zeros, which is a NOP to the unit.
- Flush:
  - req_ready is forced to 0.
  - pu_* load zeros.
  - Scoreboard entries 0 and 1 are cleared at the edge: the instruction presented to the unit this cycle, which the unit itself squashes, and the one being loaded.
  - Entries 2..DEPTH-1 are already past the squash point and keep shifting normally.
- stall_cnt increments by 1 in any cycle where some req_valid is set, no grant is given, and flush=0. It saturates at all-ones.

## Timing
- Reset (asynchronous) sets:
  - all pu_* outputs = 0, pu_sel = 0
  - scoreboard all invalid
  - last-grant pointer = 1
  - stall_cnt = 0
  - req_ready = 0 while reset is high
- Acceptance at edge t:
  - pu_* valid during cycle t+1.
  - The permute unit latches it at edge t+1; rt_wb appears during cycle t+3 and is written at edge t+4.
  - The scoreboard entry covers edges t through t+3. A dependent request is first grantable in cycle t+4.
- Back-to-back independent instructions issue one per cycle with no bubbles.
- When a request is held, its req_* inputs stay stable until ready; the block does not buffer them.
- Flush coincident with a hazard-clearing shift: clearing takes priority on entries 0 and 1, and the shift still occurs.

## Structure
- Shared package permute_pkg: the NOP encoding, the opcode/format widths (11, 3), the register-address width (7), and a scoreboard entry typedef struct {logic valid; logic [0:6] rt;}.
- One sub-module, permute_rr_arb: 2-way round-robin arbiter with a registered pointer. Everything else lives in permute_issue_ctrl.

## Test plan
- Reset mid-operation: assert reset with the scoreboard full. Required: all outputs 0 immediately, and a slot-0 request with ra=5 is granted in the first cycle after reset.
- Independent stream: slots alternately issue rt=1,2,3 with sources 10,11. Required: one grant per cycle, pu_rt_addr sequence 1,2,3, stall_cnt stays 0.
- RAW hazard: accept rt=7 at edge t; next request uses ra=7. Required: ready=0 for cycles t+1..t+3, grant in t+4, stall_cnt=3.
- Immediate form: rb=7 with uses_rb=0 and rt=7 in flight. Required: no stall.
- Both slots valid and independent for 4 cycles from reset. Required: grant order 0,1,0,1.
- Flush the cycle after accepting rt=9. Required: pu_* = 0 next cycle, entries 0 and 1 cleared, a request with ra=9 granted the cycle after flush, and stall_cnt unchanged during flush.
